// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared button FSM type, default timings and button indices for input_conditioner
package input_cond_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_HELD   = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_t;

    localparam int DB_CYCLES_DEF     = 1_000_000;
    localparam int HOLD_CYCLES_DEF   = 25_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;

    localparam int HOURS   = 0;
    localparam int MINUTES = 1;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchronizer followed by a restart-on-bounce debounce counter
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int            CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Any sample matching the current level throws away the partial count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced switches and buttons with press pulses; auto-repeat under INPUT_CONDITIONER_AUTOREPEAT_EN
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_raw,
    input  logic [1:0] btn_raw_n,
    output logic [3:0] sw_stable,
    output logic [1:0] btn_level,
    output logic [1:0] btn_pulse
);

    localparam int NBTN = MINUTES + 1;

    // Pulses could merge into a constant high level below these limits.
    if (DB_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("input_conditioner: timing parameters out of range");
    end

    for (genvar i = 0; i < 4; i++) begin : g_sw
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (sw_raw[i]),
            .stable (sw_stable[i])
        );
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_state_t state;
        btn_state_t state_nxt;
        logic       level;
        logic       pulse;

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
        localparam int            HW       = cnt_width(HOLD_CYCLES);
        localparam int            RW       = cnt_width(REPEAT_CYCLES);
        localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
        localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);

        logic [HW-1:0] hold_cnt;
        logic [HW-1:0] hold_nxt;
        logic [RW-1:0] rep_cnt;
        logic [RW-1:0] rep_nxt;
`endif

        // Buttons are inverted up front so that a cleared synchronizer means released.
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (~btn_raw_n[i]),
            .stable (btn_level[i])
        );

        assign level        = btn_level[i];
        assign btn_pulse[i] = pulse;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= BTN_IDLE;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
                hold_cnt <= '0;
                rep_cnt  <= '0;
`endif
            end else begin
                state <= state_nxt;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
                hold_cnt <= hold_nxt;
                rep_cnt  <= rep_nxt;
`endif
            end
        end

        // Counters default to zero so every state that does not count clears them.
        always_comb begin
            state_nxt = state;
            pulse     = 1'b0;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
            hold_nxt  = '0;
            rep_nxt   = '0;
`endif
            case (state)
                BTN_IDLE: begin
                    if (level) begin
                        state_nxt = BTN_HELD;
                        pulse     = 1'b1;
                    end
                end
                BTN_HELD: begin
                    if (!level) begin
                        state_nxt = BTN_IDLE;
                    end
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
                    else if (hold_cnt == HOLD_MAX) begin
                        state_nxt = BTN_REPEAT;
                        pulse     = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
`endif
                end
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
                BTN_REPEAT: begin
                    if (!level) begin
                        state_nxt = BTN_IDLE;
                    end else if (rep_cnt == REP_MAX) begin
                        pulse = 1'b1;
                    end else begin
                        rep_nxt = rep_cnt + 1'b1;
                    end
                end
`endif
                default: state_nxt = BTN_IDLE;
            endcase
        end
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000: cycles a raw input must hold a new level before acceptance (20 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 25_000_000: cycles a button must be held before auto-repeat starts (500 ms).
REQ-003 Parameter REPEAT_CYCLES, default 10_000_000: auto-repeat pulse period (200 ms).
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sw_raw  input  4  raw slide switches {off, set_alarm, set_clock, switch_reset}, active-high, asynchronous to clk.
REQ-007 btn_raw_n  input  2  raw push buttons {minutes, hours}, active-low, asynchronous to clk.
REQ-008 sw_stable  output  4  debounced switch levels, to CPU PIO inputs.
REQ-009 btn_level  output  2  debounced button levels, active-high (1 = pressed).
REQ-010 btn_pulse  output  2  one-cycle pulse per accepted press or repeat, to CPU hours/minutes PIOs.

Function
REQ-011 Each raw bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Per bit, a counter SHALL increment while synchronized input differs from stable output and clear to 0 when equal; on reaching DB_CYCLES-1 the stable output SHALL take the synchronized value and the counter clears.
REQ-013 Glitches shorter than DB_CYCLES SHALL never change a stable output; a bounce restarts the count from 0.
REQ-014 Input-to-stable latency SHALL be exactly 2 + DB_CYCLES cycles for a clean edge.
REQ-015 Each button SHALL have an FSM: IDLE, HELD, REPEAT.
REQ-016 IDLE -> HELD on btn_level rising; btn_pulse asserted for exactly that one cycle; hold counter cleared.
REQ-017 HELD: hold counter increments each cycle; at HOLD_CYCLES-1 -> REPEAT, one btn_pulse, repeat counter cleared.
REQ-018 REPEAT: repeat counter increments; at REPEAT_CYCLES-1 one btn_pulse, counter clears, stays REPEAT.
REQ-019 HELD or REPEAT -> IDLE on btn_level low, same cycle, no pulse; counters cleared.
REQ-020 Both buttons SHALL be independent; simultaneous presses SHALL produce simultaneous pulses on both bits.
REQ-021 Counters SHALL be sized to hold their parameter minus one and SHALL never wrap.
REQ-022 btn_pulse SHALL never be high for two consecutive cycles.

Reset
REQ-023 reset low SHALL immediately clear synchronizers, counters, sw_stable=4'b0000, btn_level=2'b00, btn_pulse=2'b00, FSMs=IDLE.
REQ-024 After reset release, a switch already high SHALL appear on sw_stable after 2 + DB_CYCLES cycles; a button already held SHALL produce one press pulse at acceptance.
REQ-025 Reset mid-debounce or mid-repeat SHALL discard all progress; no pulse on the reset or release cycle.

Configuration
REQ-026 Macro INPUT_CONDITIONER_AUTOREPEAT_EN defined: REQ-017/018 behaviour included.
REQ-027 Macro undefined: HELD has no exit except release; no hold/repeat counters synthesized; exactly one pulse per press.

Structure
REQ-028 Shared package input_cond_pkg SHALL hold the button FSM state enum, the default cycle constants, and the button index constants (HOURS=0, MINUTES=1).
REQ-029 Sub-module debounce_bit (synchronizer + debounce counter, parameter DB_CYCLES) SHALL be instantiated six times.

Verification (DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5 in bench)
REQ-030 sw_raw[1] 0->1 clean -> sw_stable[1] rises exactly 6 cycles later; other bits unchanged.
REQ-031 sw_raw[0] 3-cycle high glitch -> sw_stable[0] stays 0; bounce 1,0,1 then steady -> acceptance 6 cycles after last edge.
REQ-032 btn_raw_n[0] held low 40 cycles, AUTOREPEAT_EN defined -> pulses at acceptance, +10, +15, +20 cycles...; none after release.
REQ-033 Same stimulus, macro undefined -> exactly one btn_pulse[0].
REQ-034 Both buttons pressed same cycle -> btn_pulse=2'b11 in one cycle.
REQ-035 reset asserted during REPEAT -> all outputs 0 same cycle; after release with button still held, one press pulse 6 cycles later.
